// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Program-counter stage of the multicycle datapath. Holds the architectural
//   PC, evaluates BEQ/BNE/BGTZ/BLEZ branch conditions, forms jump targets and
//   registers the ALU result into ALUOut for branch-target selection.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   pc_write           unconditional PC write strobe
//   pc_write_cond      conditional (branch) PC write strobe
//   pc_source[1:0]     next-PC select: 00 alu_result, 01 alu_out, 10 jump, 11 illegal
//   op_code[5:0]       opcode selecting the branch condition
//   rs_val, rt_val     register operands for the branch compare
//   alu_result         combinational ALU output
//   jump_index[25:0]   instruction bits [25:0]
//   pc                 registered PC
//   alu_out            ALUOut register (alu_result delayed one edge)
//   branch_taken       one-cycle pulse after a committed conditional write
//   pc_err             sticky: illegal pc_source or misaligned target on a write
//
// Configuration
//   PC_BRANCH_STATS_EN  adds saturating branch_count / taken_count outputs.

module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000  // must be word-aligned
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  pc_source,
  input  logic [5:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] alu_result,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] alu_out,
  output logic        branch_taken,
`ifdef PC_BRANCH_STATS_EN
  output logic [15:0] branch_count,
  output logic [15:0] taken_count,
`endif
  output logic        pc_err
);

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic        branch_taken_q, branch_taken_d;
  logic        pc_err_q, pc_err_d;

  logic [31:0] cand;
  logic        cond;
  logic        wr_en;
  logic        wr_bad;

  // Next-PC candidate. The jump region comes from the current (pre-write) PC.
  always_comb begin
    cand = alu_result;
    case (pc_source)
      2'b00:   cand = alu_result;
      2'b01:   cand = alu_out_q;
      2'b10:   cand = {pc_q[31:28], jump_index, 2'b00};
      default: cand = alu_result;  // illegal select, write is suppressed below
    endcase
  end

  // Branch condition with signed compares against zero.
  always_comb begin
    cond = 1'b0;
    case (op_code)
      OP_BEQ:  cond = (rs_val == rt_val);
      OP_BNE:  cond = (rs_val != rt_val);
      OP_BGTZ: cond = ($signed(rs_val) >  32'sd0);
      OP_BLEZ: cond = ($signed(rs_val) <= 32'sd0);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    wr_en  = pc_write | (pc_write_cond & cond);
    wr_bad = wr_en & ((pc_source == 2'b11) | (cand[1:0] != 2'b00));

    alu_out_d = alu_result;
    pc_d      = (wr_en & ~wr_bad) ? cand : pc_q;
    pc_err_d  = pc_err_q | wr_bad;
    // Only a branch that actually committed counts as taken; pc_write
    // dominates, so a simultaneous unconditional write is not a branch.
    branch_taken_d = pc_write_cond & cond & ~pc_write & ~wr_bad;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q           <= RESET_PC;
      alu_out_q      <= 32'h0;
      branch_taken_q <= 1'b0;
      pc_err_q       <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      alu_out_q      <= alu_out_d;
      branch_taken_q <= branch_taken_d;
      pc_err_q       <= pc_err_d;
    end
  end

  assign pc           = pc_q;
  assign alu_out      = alu_out_q;
  assign branch_taken = branch_taken_q;
  assign pc_err       = pc_err_q;

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] taken_count_q, taken_count_d;
  logic        is_br_op;

  always_comb begin
    is_br_op = (op_code == OP_BEQ) | (op_code == OP_BNE) |
               (op_code == OP_BGTZ) | (op_code == OP_BLEZ);
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (pc_write_cond & is_br_op & (branch_count_q != 16'hFFFF))
      branch_count_d = branch_count_q + 16'd1;
    // Counted on the edge that sets branch_taken so both counters settle together.
    if (branch_taken_d & (taken_count_q != 16'hFFFF))
      taken_count_d = taken_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count_q <= 16'h0;
      taken_count_q  <= 16'h0;
    end else begin
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, pc_write_cond;
  logic [1:0]  pc_source;
  logic [5:0]  op_code;
  logic [31:0] rs_val, rt_val, alu_result;
  logic [25:0] jump_index;
  logic [31:0] pc, alu_out;
  logic        branch_taken, pc_err;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] branch_count, taken_count;
`endif

  int checks = 0;
  int errors = 0;

  pc_branch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val),
    .alu_result(alu_result), .jump_index(jump_index),
    .pc(pc), .alu_out(alu_out), .branch_taken(branch_taken),
`ifdef PC_BRANCH_STATS_EN
    .branch_count(branch_count), .taken_count(taken_count),
`endif
    .pc_err(pc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pw, pwc;
    logic [1:0]  src;
    logic [5:0]  op;
    logic [31:0] rs, rt, alu;
    logic [25:0] ji;
    logic [31:0] e_pc, e_alu_out;
    logic        e_bt, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic pwc, input logic [1:0] src,
                       input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] alu, input logic [25:0] ji);
    pc_write = pw; pc_write_cond = pwc; pc_source = src; op_code = op;
    rs_val = rs; rt_val = rt; alu_result = alu; jump_index = ji;
  endtask

  task automatic idle();
    drive(0, 0, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 26'd0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic add(input string n, input logic pw, input logic pwc, input logic [1:0] src,
                     input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] alu, input logic [25:0] ji,
                     input logic [31:0] e_pc, input logic [31:0] e_ao,
                     input logic e_bt, input logic e_err);
    vec_t v;
    v.name = n; v.pw = pw; v.pwc = pwc; v.src = src; v.op = op; v.rs = rs; v.rt = rt;
    v.alu = alu; v.ji = ji; v.e_pc = e_pc; v.e_alu_out = e_ao; v.e_bt = e_bt; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  // Reference model: next architectural state from the instruction-set rules.
  logic [31:0] m_pc, m_ao;
  logic        m_bt, m_err;

  task automatic model_step();
    longint a, b;
    bit     c, en, ok;
    logic [31:0] tgt;
    a = $signed(rs_val);
    b = $signed(rt_val);
    case (op_code)
      6'd4:    c = (a == b);
      6'd5:    c = (a != b);
      6'd7:    c = (a > 0);
      6'd6:    c = (a <= 0);
      default: c = 0;
    endcase
    if (pc_source == 2'd0)      tgt = alu_result;
    else if (pc_source == 2'd1) tgt = m_ao;
    else                        tgt = (m_pc & 32'hF000_0000) + ({6'd0, jump_index} * 4);
    en = pc_write || (pc_write_cond && c);
    ok = (pc_source != 2'd3) && (tgt % 4 == 0);
    m_bt = !pc_write && pc_write_cond && c && ok;
    if (en && !ok) m_err = 1;
    if (en && ok)  m_pc = tgt;
    m_ao = alu_result;
  endtask

  initial begin
    reset = 1'b0;
    idle();

    // Reset state while held.
    step(); step();
    chk("rst_pc", pc, RST_PC);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_bt", {31'd0, branch_taken}, 32'd0);
    chk("rst_err", {31'd0, pc_err}, 32'd0);
    reset = 1'b1;

    //    name          pw pwc src    op     rs            rt     alu            ji       e_pc           e_alu_out     bt err
    add("jump_zero",    1, 0, 2'b10, 6'd0, 0,            0,     32'h0,         26'h0,  32'h0,         32'h0,         0, 0);
    add("fetch4",       1, 0, 2'b00, 6'd0, 0,            0,     32'h4,         26'h0,  32'h4,         32'h4,         0, 0);
    add("fetch8",       1, 0, 2'b00, 6'd0, 0,            0,     32'h8,         26'h0,  32'h8,         32'h8,         0, 0);
    add("fetchC",       1, 0, 2'b00, 6'd0, 0,            0,     32'hC,         26'h0,  32'hC,         32'hC,         0, 0);
    add("beq_target",   0, 0, 2'b00, 6'd0, 0,            0,     32'h100,       26'h0,  32'hC,         32'h100,       0, 0);
    add("beq_taken",    0, 1, 2'b01, 6'd4, 5,            5,     32'h200,       26'h0,  32'h100,       32'h200,       1, 0);
    add("bt_drop",      0, 0, 2'b00, 6'd0, 0,            0,     32'h0,         26'h0,  32'h100,       32'h0,         0, 0);
    add("bgtz_neg",     0, 1, 2'b00, 6'd7, 32'hFFFFFFFF, 0,     32'h300,       26'h0,  32'h100,       32'h300,       0, 0);
    add("blez_zero",    0, 1, 2'b01, 6'd6, 0,            0,     32'h0,         26'h0,  32'h300,       32'h0,         1, 0);
    add("bne_equal",    0, 1, 2'b00, 6'd5, 7,            7,     32'h400,       26'h0,  32'h300,       32'h400,       0, 0);
    add("both_strobes", 1, 1, 2'b00, 6'd4, 1,            1,     32'h404,       26'h0,  32'h404,       32'h404,       0, 0);
    add("jump_setup",   1, 0, 2'b00, 6'd0, 0,            0,     32'h30000010,  26'h0,  32'h30000010,  32'h30000010,  0, 0);
    add("jump",         1, 0, 2'b10, 6'd0, 0,            0,     32'h0,         26'h40, 32'h30000100,  32'h0,         0, 0);
    add("misaligned",   1, 0, 2'b00, 6'd0, 0,            0,     32'h30000102,  26'h0,  32'h30000100,  32'h30000102,  0, 1);
    add("err_sticky",   1, 0, 2'b00, 6'd0, 0,            0,     32'h30000104,  26'h0,  32'h30000104,  32'h30000104,  0, 1);
    add("bad_opcode",   0, 1, 2'b00, 6'h23, 0,           0,     32'h30000200,  26'h0,  32'h30000104,  32'h30000200,  0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pw, vecs[i].pwc, vecs[i].src, vecs[i].op,
            vecs[i].rs, vecs[i].rt, vecs[i].alu, vecs[i].ji);
      step();
      chk({vecs[i].name, ".pc"}, pc, vecs[i].e_pc);
      chk({vecs[i].name, ".alu_out"}, alu_out, vecs[i].e_alu_out);
      chk({vecs[i].name, ".bt"}, {31'd0, branch_taken}, {31'd0, vecs[i].e_bt});
      chk({vecs[i].name, ".err"}, {31'd0, pc_err}, {31'd0, vecs[i].e_err});
    end

    // Illegal pc_source: PC holds, error sticks until reset.
    do_reset();
    step();
    chk("rst_clears_err", {31'd0, pc_err}, 32'd0);
    drive(1, 0, 2'b11, 6'd0, 0, 0, RST_PC + 32'd4, 26'd0);
    step();
    chk("src11_pc_hold", pc, RST_PC);
    chk("src11_err", {31'd0, pc_err}, 32'd1);
    idle();
    step(); step();
    chk("src11_err_sticky", {31'd0, pc_err}, 32'd1);

    // Asynchronous reset mid-operation drops branch_taken and discards the write.
    do_reset();
    drive(0, 0, 2'b00, 6'd0, 0, 0, RST_PC + 32'h80, 26'd0);
    step();
    drive(0, 1, 2'b01, 6'd4, 9, 9, 32'd0, 26'd0);
    step();
    chk("pre_async_bt", {31'd0, branch_taken}, 32'd1);
    drive(0, 1, 2'b00, 6'd4, 9, 9, RST_PC + 32'h40, 26'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_bt_drop", {31'd0, branch_taken}, 32'd0);
    chk("async_pc", pc, RST_PC);
    step();
    chk("async_write_discard", pc, RST_PC);
    reset = 1'b1;
    idle();

`ifdef PC_BRANCH_STATS_EN
    do_reset();
    step();
    drive(0, 1, 2'b00, 6'd5, 1, 2, RST_PC + 32'h10, 26'd0); step();
    drive(0, 1, 2'b00, 6'd5, 3, 3, RST_PC + 32'h20, 26'd0); step();
    drive(0, 1, 2'b00, 6'd5, 4, 5, RST_PC + 32'h30, 26'd0); step();
    idle(); step();
    chk("stats_branch_count", {16'd0, branch_count}, 32'd3);
    chk("stats_taken_count", {16'd0, taken_count}, 32'd2);
    drive(0, 1, 2'b00, 6'd5, 1, 2, RST_PC, 26'd0);
    repeat (65540) step();
    chk("stats_branch_sat", {16'd0, branch_count}, 32'h0000FFFF);
    chk("stats_taken_sat", {16'd0, taken_count}, 32'h0000FFFF);
    idle();
`endif

    // Randomized run against the reference model.
    do_reset();
    step();
    m_pc = RST_PC; m_ao = 0; m_bt = 0; m_err = 0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] vals[5];
      logic [5:0]  ops[5];
      logic [31:0] a;
      if (n % 50 == 49) begin
        do_reset();
        step();
        m_pc = RST_PC; m_ao = 0; m_bt = 0; m_err = 0;
      end
      vals[0] = 0; vals[1] = 1; vals[2] = 32'hFFFFFFFF; vals[3] = 32'h80000000; vals[4] = $urandom();
      ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'd6; ops[3] = 6'd7; ops[4] = 6'($urandom());
      a = $urandom();
      if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            ops[$urandom_range(0, 4)], vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)],
            a, 26'($urandom()));
      model_step();
      step();
      chk("rand_pc", pc, m_pc);
      chk("rand_alu_out", alu_out, m_ao);
      chk("rand_bt", {31'd0, branch_taken}, {31'd0, m_bt});
      chk("rand_err", {31'd0, pc_err}, {31'd0, m_err});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter stage of the multicycle datapath. It consumes the PC-control strobes issued by the control unit and holds the architectural PC. It evaluates branch conditions for BEQ, BNE, BGTZ and BLEZ, forms jump targets, and latches the ALU result into the ALUOut register that feeds branch-target selection. Its `pc` output drives the instruction-memory address path ahead of instruction fetch.

## Interface
Reset: one clock; reset is asynchronous and active-low, ports named `clk` and `reset`.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_write`  in  1  unconditional PC write strobe.
- `pc_write_cond`  in  1  conditional PC write strobe (branch).
- `pc_source`  in  2  next-PC select.
- `op_code`  in  6  opcode of the current instruction.
- `rs_val`  in  32  register-file A operand.
- `rt_val`  in  32  register-file B operand.
- `alu_result`  in  32  combinational ALU output.
- `jump_index`  in  26  instruction bits [25:0].
- `pc`  out  32  current PC (registered).
- `alu_out`  out  32  ALUOut register.
- `branch_taken`  out  1  one-cycle pulse after a taken conditional write.
- `pc_err`  out  1  sticky error flag.

## Operation
- `alu_out` is loaded from `alu_result` on every rising edge, with no enable.
- Next-PC candidate is selected by `pc_source`:
  - 00: `alu_result` (PC+4 path).
  - 01: `alu_out` (branch target).
  - 10: `{pc[31:28], jump_index, 2'b00}`.
  - 11: illegal.
- Branch condition, selected by `op_code`, with signed compares:
  - 000100 BEQ: `rs_val == rt_val`.
  - 000101 BNE: `rs_val != rt_val`.
  - 000111 BGTZ: `rs_val > 0`.
  - 000110 BLEZ: `rs_val <= 0`.
  - Any other opcode: condition false.
- The write enable is `pc_write | (pc_write_cond & cond)`. When both strobes are high, `pc_write` dominates and the write is unconditional.
- Write suppression (PC holds, `pc_err` set):
  - enabled write with `pc_source == 11`;
  - enabled write whose candidate has bits [1:0] != 0.
- `pc_err` is sticky and is cleared only by reset.
- `branch_taken` is registered and is 1 for exactly the cycle after an edge where `pc_write_cond & cond` committed a write while `pc_write` was 0.

## Timing
- Reset values while `reset`=0:
  - `pc`=`RESET_PC`
  - `alu_out`=0
  - `branch_taken`=0
  - `pc_err`=0
  - stats counters = 0
- Reset takes effect immediately and is asynchronous. Deassertion is sampled at the next rising edge.
- PC latency: a strobe sampled at edge N makes `pc` show the new value after edge N, so it is visible in cycle N+1.
- `alu_out` lags `alu_result` by one edge. A branch target computed in DECODE is therefore usable under `pc_source`=01 in EXECUTE.
- When `pc_source`=10 in the same cycle as a write, `pc[31:28]` is taken from the pre-write PC.
- Reset asserted mid-operation discards any pending write. `branch_taken` drops immediately.
- There is no handshake: strobes are single-cycle levels and are evaluated every edge.

## Configuration
- `PC_BRANCH_STATS_EN` defined:
  - Adds outputs `branch_count[15:0]` and `taken_count[15:0]`.
  - `branch_count` increments on every edge with `pc_write_cond`=1 and a branch opcode.
  - `taken_count` increments when `branch_taken` is set.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset: hold `reset`=0 with `RESET_PC`=32'h0040_0000, then release -> `pc`=32'h0040_0000, `pc_err`=0, `alu_out`=0.
- Sequential fetch: `pc_write`=1, `pc_source`=00, `alu_result`=pc+4 for 3 edges -> `pc` steps 0x0, 0x4, 0x8, 0xC.
- Taken BEQ:
  - Stimulus: `alu_result`=0x100 in one cycle; next cycle `pc_write_cond`=1, `op_code`=000100, `rs_val`=`rt_val`=5, `pc_source`=01.
  - Response: `pc`=0x100 and `branch_taken`=1 for one cycle.
- Branch sign edge cases:
  - BGTZ with `rs_val`=32'hFFFF_FFFF -> not taken, PC unchanged.
  - BLEZ with `rs_val`=0 -> taken.
- Jump and errors:
  - `pc`=0x3000_0010, `jump_index`=26'h0000040, `pc_source`=10, `pc_write`=1 -> `pc`=0x3000_0100.
  - `pc_source`=11 with `pc_write`=1 -> PC holds, `pc_err`=1 until reset.
- Stats (`PC_BRANCH_STATS_EN`): 3 BNE strobes, 2 taken -> `branch_count`=3, `taken_count`=2. With counters preloaded near 16'hFFFF, they saturate at 16'hFFFF.
